// File: rtl/bcd2b_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// The saturation option (BCD2B_SAT_EN) is applied in bcd2b through finish_chan().
package bcd2b_pkg;

    localparam int NDIG    = 4;
    localparam int W_OUT   = 12;
    localparam int W_ACC   = 14;
    localparam int W_IDX   = $clog2(NDIG);
    localparam int MAXV    = (2 ** W_OUT) - 1;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CH1  = 2'd1,
        CH2  = 2'd2
    } state_e;

    typedef logic [NDIG-1:0][3:0] digits_t;

    typedef struct packed {
        logic [W_OUT-1:0] v;
        logic             err;
        logic             ovf;
    } chan_res_t;

    // An invalid digit forces the value to zero and masks overflow for that channel.
    function automatic chan_res_t finish_chan(input logic [W_ACC-1:0] acc,
                                              input logic             bad,
                                              input logic             sat);
        chan_res_t r;
        r.v   = acc[W_OUT-1:0];
        r.err = bad;
        r.ovf = 1'b0;
        if (bad) begin
            r.v = '0;
        end else if (acc > W_ACC'(MAXV)) begin
            r.ovf = 1'b1;
            if (sat) begin
                r.v = W_OUT'(MAXV);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd2b_digit_mac.sv
// One decimal multiply-accumulate step: acc*10 + digit, plus a digit range check.
// Purely combinational; the converter shares a single instance between both channels.
module bcd_digit_mac
    import bcd2b_pkg::*;
(
    input  logic [W_ACC-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [W_ACC-1:0] acc_o,
    output logic             digit_ok_o
);

    logic [W_ACC-1:0] acc_x8;
    logic [W_ACC-1:0] acc_x2;
    logic [W_ACC-1:0] digit_ext;

    always_comb begin
        acc_x8     = acc_i << 3;
        acc_x2     = acc_i << 1;
        digit_ext  = {{(W_ACC-4){1'b0}}, digit_i};
        acc_o      = acc_x8 + acc_x2 + digit_ext;
        digit_ok_o = (digit_i <= 4'(BCD_MAX));
    end

endmodule

// File: rtl/bcd2b.sv
// Two-channel 4-digit packed-BCD to 12-bit binary converter, one digit per clock.
// Define BCD2B_SAT_EN to clamp overflowing results to 4095 instead of wrapping modulo 4096.
module bcd2b
    import bcd2b_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       DV10,
    input  logic [3:0]       DV11,
    input  logic [3:0]       DV12,
    input  logic [3:0]       DV13,
    input  logic [3:0]       DV20,
    input  logic [3:0]       DV21,
    input  logic [3:0]       DV22,
    input  logic [3:0]       DV23,
    output logic [W_OUT-1:0] v1,
    output logic [W_OUT-1:0] v2,
    output logic             busy,
    output logic             done,
    output logic             err1,
    output logic             err2,
    output logic             ovf1,
    output logic             ovf2
);

`ifdef BCD2B_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [W_IDX-1:0] idx_q, idx_d;
    logic [W_ACC-1:0] acc_q, acc_d;
    logic             run_err_q, run_err_d;
    digits_t          dig1_q, dig1_d;
    digits_t          dig2_q, dig2_d;
    logic [W_ACC-1:0] hold_acc_q, hold_acc_d;
    logic             hold_err_q, hold_err_d;
    logic [W_OUT-1:0] v1_q, v1_d;
    logic [W_OUT-1:0] v2_q, v2_d;
    logic             err1_q, err1_d;
    logic             err2_q, err2_d;
    logic             ovf1_q, ovf1_d;
    logic             ovf2_q, ovf2_d;
    logic             done_q, done_d;

    logic [3:0]       cur_digit;
    logic [W_ACC-1:0] mac_acc;
    logic             mac_ok;
    logic             last_digit;
    logic             chan_bad;
    chan_res_t        res1;
    chan_res_t        res2;

    always_comb begin
        cur_digit  = (state_q == CH2) ? dig2_q[idx_q] : dig1_q[idx_q];
        last_digit = (idx_q == '0);
        chan_bad   = run_err_q | ~mac_ok;
    end

    bcd_digit_mac u_mac (
        .acc_i      (acc_q),
        .digit_i    (cur_digit),
        .acc_o      (mac_acc),
        .digit_ok_o (mac_ok)
    );

    // Channel 1 finished one phase earlier and waits in the holding regs.
    always_comb begin
        res1 = finish_chan(hold_acc_q, hold_err_q, SAT_EN);
        res2 = finish_chan(mac_acc, chan_bad, SAT_EN);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        run_err_d  = run_err_q;
        dig1_d     = dig1_q;
        dig2_d     = dig2_q;
        hold_acc_d = hold_acc_q;
        hold_err_d = hold_err_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        err1_d     = err1_q;
        err2_d     = err2_q;
        ovf1_d     = ovf1_q;
        ovf2_d     = ovf2_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dig1_d    = {DV13, DV12, DV11, DV10};
                    dig2_d    = {DV23, DV22, DV21, DV20};
                    acc_d     = '0;
                    run_err_d = 1'b0;
                    idx_d     = W_IDX'(NDIG - 1);
                    state_d   = CH1;
                end
            end
            CH1: begin
                acc_d     = mac_acc;
                run_err_d = chan_bad;
                if (last_digit) begin
                    hold_acc_d = mac_acc;
                    hold_err_d = chan_bad;
                    acc_d      = '0;
                    run_err_d  = 1'b0;
                    idx_d      = W_IDX'(NDIG - 1);
                    state_d    = CH2;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            CH2: begin
                acc_d     = mac_acc;
                run_err_d = chan_bad;
                if (last_digit) begin
                    v1_d    = res1.v;
                    err1_d  = res1.err;
                    ovf1_d  = res1.ovf;
                    v2_d    = res2.v;
                    err2_d  = res2.err;
                    ovf2_d  = res2.ovf;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            run_err_q  <= 1'b0;
            dig1_q     <= '0;
            dig2_q     <= '0;
            hold_acc_q <= '0;
            hold_err_q <= 1'b0;
            v1_q       <= '0;
            v2_q       <= '0;
            err1_q     <= 1'b0;
            err2_q     <= 1'b0;
            ovf1_q     <= 1'b0;
            ovf2_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            run_err_q  <= run_err_d;
            dig1_q     <= dig1_d;
            dig2_q     <= dig2_d;
            hold_acc_q <= hold_acc_d;
            hold_err_q <= hold_err_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            err1_q     <= err1_d;
            err2_q     <= err2_d;
            ovf1_q     <= ovf1_d;
            ovf2_q     <= ovf2_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        v1   = v1_q;
        v2   = v2_q;
        err1 = err1_q;
        err2 = err2_q;
        ovf1 = ovf1_q;
        ovf2 = ovf2_q;
        done = done_q;
        busy = (state_q != IDLE);
    end

endmodule

// File: tb/tb_bcd2b.sv
// Scoreboard bench for bcd2b: drivers push hand-computed results, a negedge monitor pops on done.
// Expected overflow values follow BCD2B_SAT_EN the same way the design does.
module tb_bcd2b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  DV10, DV11, DV12, DV13;
    logic [3:0]  DV20, DV21, DV22, DV23;
    logic [11:0] v1, v2;
    logic        busy, done, err1, err2, ovf1, ovf2;

`ifdef BCD2B_SAT_EN
    localparam logic [11:0] OV_9999 = 12'd4095;
    localparam logic [11:0] OV_4096 = 12'd4095;
    localparam logic [11:0] OV_9876 = 12'd4095;
`else
    localparam logic [11:0] OV_9999 = 12'd1807;
    localparam logic [11:0] OV_4096 = 12'd0;
    localparam logic [11:0] OV_9876 = 12'd1684;
`endif

    bcd2b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .DV10  (DV10),
        .DV11  (DV11),
        .DV12  (DV12),
        .DV13  (DV13),
        .DV20  (DV20),
        .DV21  (DV21),
        .DV22  (DV22),
        .DV23  (DV23),
        .v1    (v1),
        .v2    (v2),
        .busy  (busy),
        .done  (done),
        .err1  (err1),
        .err2  (err2),
        .ovf1  (ovf1),
        .ovf2  (ovf2)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: {v1, v2, err1, err2, ovf1, ovf2}
    logic [27:0] exp_q[$];
    int unsigned t_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_pushed = 0;
    int n_dones  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_exp(input logic [11:0] e_v1, input logic [11:0] e_v2,
                            input logic e_err1, input logic e_err2,
                            input logic e_ovf1, input logic e_ovf2);
        exp_q.push_back({e_v1, e_v2, e_err1, e_err2, e_ovf1, e_ovf2});
        t_q.push_back(cyc);
        n_pushed++;
    endtask

    // monitor: done is registered, so it shows 9 negedges after the driver's launch negedge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done !== 1'b0) begin
            n_dones++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=%b expected no done (t=%0t)", done, $time);
            end else begin
                logic [27:0] e;
                int unsigned t0;
                e  = exp_q.pop_front();
                t0 = t_q.pop_front();
                check("v1",      32'(v1),   32'(e[27:16]));
                check("v2",      32'(v2),   32'(e[15:4]));
                check("err1",    32'(err1), 32'(e[3]));
                check("err2",    32'(err2), 32'(e[2]));
                check("ovf1",    32'(ovf1), 32'(e[1]));
                check("ovf2",    32'(ovf2), 32'(e[0]));
                check("latency", cyc - t0,  32'd9);
            end
        end
    end

    // driver tasks
    task automatic set_inputs(input logic [15:0] c1, input logic [15:0] c2);
        {DV13, DV12, DV11, DV10} = c1;
        {DV23, DV22, DV21, DV20} = c2;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            t_q.delete();
        end
    endtask

    task automatic run_conv(input logic [15:0] c1, input logic [15:0] c2,
                            input logic [11:0] e_v1, input logic [11:0] e_v2,
                            input logic e_err1, input logic e_err2,
                            input logic e_ovf1, input logic e_ovf2,
                            output int busy_cycles);
        wait_idle();
        set_inputs(c1, c2);
        start = 1'b1;
        push_exp(e_v1, e_v2, e_err1, e_err2, e_ovf1, e_ovf2);
        @(posedge clk);
        #1 start = 1'b0;
        set_inputs(16'h9999, 16'h9999);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            busy_cycles++;
        end
        drain();
    endtask

    task automatic wait_done_cycle();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("held_start_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int bc;
        rst_n = 1'b0;
        start = 1'b1;
        set_inputs(16'h1234, 16'h5678);

        // reset with start asserted
        repeat (3) @(negedge clk);
        check("rst_v1",   32'(v1),   32'd0);
        check("rst_v2",   32'(v2),   32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err1", 32'(err1), 32'd0);
        check("rst_err2", 32'(err2), 32'd0);
        check("rst_ovf1", 32'(ovf1), 32'd0);
        check("rst_ovf2", 32'(ovf2), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset_busy", 32'(busy), 32'd0);

        // basic conversion and busy width
        run_conv(16'h0123, 16'h4095, 12'd123, 12'd4095, 1'b0, 1'b0, 1'b0, 1'b0, bc);
        check("busy_cycles", 32'(bc), 32'd8);

        // overflow on both channels
        run_conv(16'h9999, 16'h4096, OV_9999, OV_4096, 1'b0, 1'b0, 1'b1, 1'b1, bc);
        // invalid digit on channel 1 only
        run_conv(16'h12C4, 16'h0007, 12'd0, 12'd7, 1'b1, 1'b0, 1'b0, 1'b0, bc);
        // flags are not sticky
        run_conv(16'h0000, 16'h0000, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, bc);
        // exact maximum without overflow; invalid MS digit on channel 2
        run_conv(16'h4095, 16'hF000, 12'd4095, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, bc);

        // start re-pulsed mid-conversion is ignored
        wait_idle();
        set_inputs(16'h1000, 16'h2048);
        start = 1'b1;
        push_exp(12'd1000, 12'd2048, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        set_inputs(16'h0001, 16'h0001);
        @(posedge clk);
        #1 start = 1'b0;
        drain();
        repeat (12) @(negedge clk);

        // start held high: back-to-back conversions, inputs changed right after each sample
        wait_idle();
        set_inputs(16'h0050, 16'h3210);
        start = 1'b1;
        push_exp(12'd50, 12'd3210, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 set_inputs(16'h0001, 16'h9876);
        wait_done_cycle();
        push_exp(12'd1, OV_9876, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 set_inputs(16'h9999, 16'h00B0);
        wait_done_cycle();
        push_exp(OV_9999, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        set_inputs(16'h5555, 16'h5555);
        drain();

        // asynchronous abort at T+5
        wait_idle();
        set_inputs(16'h1111, 16'h2222);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_v1",   32'(v1),   32'd0);
        check("abort_v2",   32'(v2),   32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ovf1", 32'(ovf1), 32'd0);
        check("abort_err2", 32'(err2), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_resume_busy", 32'(busy), 32'd0);

        // clean conversion after abort
        run_conv(16'h0042, 16'h4000, 12'd42, 12'd4000, 1'b0, 1'b0, 1'b0, 1'b0, bc);
        check("post_abort_busy_cycles", 32'(bc), 32'd8);

        repeat (4) @(negedge clk);
        check("done_count", 32'(n_dones), 32'(n_pushed));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
